// File: rtl/alu_pkg.sv
// Shared opcode encodings, mul/div FSM states and decode helpers for the
// execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_MFLO  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MFHI  = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// cycle on sign-stripped operands, sign correction on the final step.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_e          state_q, state_d;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] work_q, work_d, mul_next, div_next, prod;
  logic [WIDTH-1:0]   b_mag_q, hi_q, lo_q;
  logic               is_div_q, neg_q, neg_rem_q, dz_q;

  logic               launch, last, signed_op, a_neg, b_neg, div_ok;
  logic [WIDTH-1:0]   a_mag, b_mag, rem_sub, quot, rem, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, rem_sh;

  assign launch = start_i && is_muldiv(alu_ctrl_i);
  assign last   = (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    signed_op = (alu_ctrl_i == OP_MULT) || (alu_ctrl_i == OP_DIV);
    a_neg     = signed_op && src_a_i[WIDTH-1];
    b_neg     = signed_op && src_b_i[WIDTH-1];
    a_mag     = a_neg ? -src_a_i : src_a_i;
    b_mag     = b_neg ? -src_b_i : src_b_i;
  end

  // Working register is {upper, lower}: multiplier/dividend starts in lower.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_mag_q} : '0);
    mul_next = {mul_sum, work_q[WIDTH-1:1]};
    rem_sh   = work_q[2*WIDTH-1:WIDTH-1];
    div_ok   = rem_sh >= {1'b0, b_mag_q};
    rem_sub  = rem_sh[WIDTH-1:0] - b_mag_q;
    div_next = {div_ok ? rem_sub : rem_sh[WIDTH-1:0], work_q[WIDTH-2:0], div_ok};
    work_d   = is_div_q ? div_next : mul_next;
    prod     = neg_q ? -work_d : work_d;
    quot     = work_d[WIDTH-1:0];
    rem      = work_d[2*WIDTH-1:WIDTH];
    // Divide by zero leaves rem = |dividend|, so the remainder fix-up alone
    // restores src_a; only the quotient needs forcing.
    res_lo   = is_div_q ? (dz_q ? {WIDTH{1'b1}} : (neg_q ? -quot : quot))
                        : prod[WIDTH-1:0];
    res_hi   = is_div_q ? (neg_rem_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    // NOTE: state_d takes a default before the case so every path assigns it
    // and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (launch) state_d = MD_CALC;
      MD_CALC: if (last) state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register resets, including the working set, so an aborted
      // op leaves nothing behind; non-blocking assignments throughout.
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      b_mag_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == MD_IDLE && launch) begin
        work_q    <= {{WIDTH{1'b0}}, a_mag};
        b_mag_q   <= b_mag;
        is_div_q  <= (alu_ctrl_i == OP_DIV) || (alu_ctrl_i == OP_DIVU);
        neg_q     <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dz_q      <= (src_b_i == '0);
        cnt_q     <= '0;
      end else if (state_q == MD_CALC) begin
        work_q <= work_d;
        cnt_q  <= cnt_q + SHW'(1);
        if (last) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = (state_q == MD_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_md.sv
// Execute-stage ALU: combinational arithmetic/logic/shift ops and result mux,
// with the iterative multiply/divide unit supplying HI/LO.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  input  logic             start,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] add_res, sub_res;

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_ctrl_i(alu_ctrl),
    .src_a_i   (src_a),
    .src_b_i   (src_b),
    .start_i   (start),
    .busy_o    (busy),
    .done_o    (done),
    .hi_o      (hi),
    .lo_o      (lo)
  );

  assign add_res = src_a + src_b;
  assign sub_res = src_a - src_b;

  always_comb begin
    alu_result = '0;
    overflow   = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        alu_result = add_res;
        overflow   = (src_a[MSB] == src_b[MSB]) && (add_res[MSB] != src_a[MSB]);
      end
      OP_SUB: begin
        alu_result = sub_res;
        overflow   = (src_a[MSB] != src_b[MSB]) && (sub_res[MSB] != src_a[MSB]);
      end
      OP_AND:  alu_result = src_a & src_b;
      OP_OR:   alu_result = src_a | src_b;
      OP_XOR:  alu_result = src_a ^ src_b;
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, src_a < src_b};
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_MFLO: alu_result = lo;
      OP_SLL:  alu_result = src_a << shamt;
      OP_SRL:  alu_result = src_a >> shamt;
      OP_SRA:  alu_result = $signed(src_a) >>> shamt;
      OP_MFHI: alu_result = hi;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed tables, randomized ops against an
// arithmetic reference model, and hand-written mul/div handshake sequences.
module tb_alu_md;
  import alu_pkg::*;

  localparam int W   = 32;
  localparam int SHW = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   src_a, src_b;
  logic [SHW-1:0] shamt;
  logic           start;
  logic [W-1:0]   alu_result, hi, lo;
  logic           zero, overflow, busy, done;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
    .shamt(shamt), .start(start), .alu_result(alu_result), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [3:0]     op;
    logic [W-1:0]   a, b;
    logic [SHW-1:0] sh;
    logic [W-1:0]   res;
    logic           z, ovf;
  } comb_vec_t;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] exp_hi, exp_lo;
  } md_vec_t;

  int vectors     = 0;
  int miscompares = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void comb_model(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [SHW-1:0] sh,
                                     output logic [W-1:0] r, output logic ovf);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    r   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD:  begin s = sa + sb; r = W'(s); ovf = (s != longint'($signed(r))); end
      OP_SUB:  begin s = sa - sb; r = W'(s); ovf = (s != longint'($signed(r))); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLTU: r = (a < b) ? 1 : 0;
      OP_SLT:  r = (sa < sb) ? 1 : 0;
      OP_MFLO: r = model_lo;
      OP_SLL:  r = W'(a * (64'd1 << sh));
      OP_SRL:  r = W'({32'b0, a} / (64'd1 << sh));
      OP_SRA:  r = W'(sa >>> sh);
      OP_MFHI: r = model_hi;
      default: r = '0;
    endcase
  endfunction

  function automatic void md_model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] h,
                                   output logic [W-1:0] l);
    logic [63:0] p;
    p = '0;
    if (op == OP_MULT)  p = longint'($signed(a)) * longint'($signed(b));
    if (op == OP_MULTU) p = {32'b0, a} * {32'b0, b};
    h = p[63:32];
    l = p[31:0];
    if (op == OP_DIV) begin
      if (b == 0) begin l = '1; h = a; end
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = a; h = '0; end
      else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
    end
    if (op == OP_DIVU) begin
      if (b == 0) begin l = '1; h = a; end
      else begin l = a / b; h = a % b; end
    end
  endfunction

  task automatic run_md(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int lat = 0;
    @(negedge clk);
    alu_ctrl = op; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    check({name, " busy_after_start"}, busy, 1);
    start = 1'b0;
    for (int n = 1; n <= W + 8; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    check({name, " done_latency"}, lat, W);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
    check({name, " busy_in_done"}, busy, 1);
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, done, 0);
    check({name, " idle_after"}, busy, 0);
    model_hi = eh;
    model_lo = el;
  endtask

  task automatic apply_comb(input string name, input comb_vec_t v);
    @(negedge clk);
    alu_ctrl = v.op; src_a = v.a; src_b = v.b; shamt = v.sh; start = 1'b0;
    #1;
    check({name, " result"}, alu_result, v.res);
    check({name, " zero"}, zero, v.z);
    check({name, " overflow"}, overflow, v.ovf);
  endtask

  comb_vec_t cv[16];
  md_vec_t   mv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cv[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b0, 1'b1};
    cv[1]  = '{OP_SUB,  32'h5,         32'h5,         5'd0,  32'h0,         1'b1, 1'b0};
    cv[2]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         1'b0, 1'b0};
    cv[3]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b1, 1'b0};
    cv[4]  = '{OP_SRA,  32'h8000_0000, 32'h0,         5'd4,  32'hF800_0000, 1'b0, 1'b0};
    cv[5]  = '{OP_SRL,  32'h8000_0000, 32'h0,         5'd4,  32'h0800_0000, 1'b0, 1'b0};
    cv[6]  = '{OP_SLL,  32'h1,         32'h0,         5'd31, 32'h8000_0000, 1'b0, 1'b0};
    cv[7]  = '{OP_SUB,  32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1};
    cv[8]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b1, 1'b0};
    cv[9]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0};
    cv[10] = '{OP_XOR,  32'hA5A5_A5A5, 32'hFFFF_FFFF, 5'd0,  32'h5A5A_5A5A, 1'b0, 1'b0};
    cv[11] = '{OP_MFHI, 32'h1234,      32'h5678,      5'd0,  32'h0,         1'b1, 1'b0};
    cv[12] = '{OP_MFLO, 32'h1234,      32'h5678,      5'd0,  32'h0,         1'b1, 1'b0};
    cv[13] = '{OP_MULT, 32'h3,         32'h7,         5'd0,  32'h0,         1'b1, 1'b0};
    cv[14] = '{OP_SRA,  32'h7FFF_FFFF, 32'h0,         5'd31, 32'h0,         1'b1, 1'b0};
    cv[15] = '{OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 5'd0,  32'h1,         1'b0, 1'b0};

    mv[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    mv[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE};
    mv[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    mv[3] = '{OP_DIVU,  32'h7,         32'h0,         32'h7,         32'hFFFF_FFFF};
    mv[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    mv[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    mv[6] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    mv[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

    rst_n = 1'b0; alu_ctrl = OP_ADD; src_a = '0; src_b = '0; shamt = '0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) apply_comb($sformatf("comb_dir[%0d]", i), cv[i]);

    // start with a non-mul/div op must not launch anything
    @(negedge clk);
    alu_ctrl = OP_ADD; start = 1'b1;
    @(posedge clk); #1;
    check("start_non_md ignored", busy, 0);
    start = 1'b0;

    for (int i = 0; i < 8; i++)
      run_md($sformatf("md_dir[%0d]", i), mv[i].op, mv[i].a, mv[i].b, mv[i].exp_hi, mv[i].exp_lo);

    for (int i = 0; i < 120; i++) begin
      comb_vec_t v;
      v.op = 4'($urandom_range(0, 15));
      v.a  = $urandom;
      v.b  = (i % 4 == 0) ? v.a ^ (32'h1 << $urandom_range(0, 31)) : $urandom;
      v.sh = 5'($urandom);
      comb_model(v.op, v.a, v.b, v.sh, v.res, v.ovf);
      v.z = (v.res == 0);
      apply_comb($sformatf("comb_rnd[%0d] op=%0h", i, v.op), v);
    end

    for (int i = 0; i < 8; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b, eh, el;
      op = OP_MULT + 4'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) b = -b;
      md_model(op, a, b, eh, el);
      run_md($sformatf("md_rnd[%0d] op=%0h", i, op), op, a, b, eh, el);
    end

    // Second start and operand changes while CALC must not disturb the op.
    begin
      logic [W-1:0] eh, el, old_lo;
      int got = 0;
      old_lo = model_lo;
      md_model(OP_MULTU, 32'h1234, 32'h10, eh, el);
      @(negedge clk);
      alu_ctrl = OP_MULTU; src_a = 32'h1234; src_b = 32'h10; start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 5; n++) begin
        @(negedge clk);
        alu_ctrl = OP_DIVU; src_a = $urandom; src_b = '0; start = 1'b1;
      end
      @(negedge clk);
      alu_ctrl = OP_MFLO; start = 1'b0;
      #1;
      check("midop mflo_stale", alu_result, old_lo);
      check("midop busy", busy, 1);
      for (int n = 0; n < W + 8; n++) begin
        @(posedge clk); #1;
        if (done) begin got = 1; break; end
      end
      check("midop done_seen", got, 1);
      check("midop hi", hi, eh);
      check("midop lo", lo, el);
      @(posedge clk); #1;
      model_hi = eh;
      model_lo = el;
    end

    // Asynchronous reset in the middle of CALC aborts the op.
    @(negedge clk);
    alu_ctrl = OP_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'h7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
    run_md("post_reset mult", OP_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
